// File: rtl/test_loopback.sv
// Far-end loopback: stores MAC rx frames in a ring buffer, commits the good ones
// and replays them unchanged on the MAC tx interface with an enforced inter-frame gap.
module test_loopback #(
  parameter int TEST_DATA_WIDTH = 8,
  parameter int ADDR_WIDTH      = 11,
  parameter int LEN_FIFO_AW     = 2,
  parameter int IFG_CYCLES      = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [TEST_DATA_WIDTH-1:0] mac_rx_data,
  input  logic                       mac_rx_valid,
  input  logic                       mac_rx_sof,
  input  logic                       mac_rx_eof,
  input  logic                       mac_rx_fr_good,
  input  logic                       mac_rx_fr_err,
  output logic [TEST_DATA_WIDTH-1:0] mac_tx_data,
  output logic                       mac_tx_valid,
  output logic                       mac_tx_sof,
  output logic                       mac_tx_eof,
  input  logic                       enable,
  output logic [15:0]                frame_cnt,
  output logic [15:0]                drop_cnt,
  output logic                       busy
);

  typedef logic [ADDR_WIDTH:0] ptr_t;
  typedef enum logic [1:0] {R_IDLE, R_RECV, R_DROP} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_SEND, T_GAP} tx_state_t;

  localparam ptr_t        ONE      = ptr_t'(1);
  localparam logic [15:0] IFG_LOAD = (IFG_CYCLES > 0) ? 16'(IFG_CYCLES - 1) : 16'd0;

  // Occupancy reaching the full depth sets the extra pointer bit of the difference.
  function automatic logic ptr_full(input ptr_t w, input ptr_t r);
    ptr_t d;
    d = w - r;
    return d[ADDR_WIDTH];
  endfunction

  logic [TEST_DATA_WIDTH-1:0] buf_mem [2**ADDR_WIDTH];
  ptr_t                       len_mem [2**LEN_FIFO_AW];

  rx_state_t rx_state, rx_nxt;
  tx_state_t tx_state, tx_nxt;
  ptr_t wr_ptr, wr_ptr_nxt, wr_base, wr_base_nxt, rd_ptr, start_ptr;
  ptr_t push_len, head_len, len_rem, len_rem_nxt;
  logic [ADDR_WIDTH-1:0] mem_wa;
  logic mem_we, start_sof, frame_ok;
  logic [1:0] drop_inc;
  logic [LEN_FIFO_AW:0] lf_wr, lf_rd, lf_used;
  logic lf_empty, lf_full, lf_push, lf_pop;
  logic [15:0] ifg_cnt, ifg_nxt;
  logic rd_en_p0, sof_p0, eof_p0;
  logic vld_p1, sof_p1, eof_p1;
  logic [TEST_DATA_WIDTH-1:0] data_p1;

  assign lf_used  = lf_wr - lf_rd;
  assign lf_empty = (lf_used == '0);
  assign lf_full  = lf_used[LEN_FIFO_AW];
  assign head_len = len_mem[lf_rd[LEN_FIFO_AW-1:0]];
  assign frame_ok = mac_rx_fr_good & ~mac_rx_fr_err;
  assign busy     = ~lf_empty | (tx_state != T_IDLE) | vld_p1 | mac_tx_valid;

  // Receive side: speculative writes, rewound to wr_base when a frame is discarded.
  always_comb begin
    rx_nxt      = rx_state;
    wr_ptr_nxt  = wr_ptr;
    wr_base_nxt = wr_base;
    mem_we      = 1'b0;
    mem_wa      = wr_ptr[ADDR_WIDTH-1:0];
    lf_push     = 1'b0;
    push_len    = '0;
    drop_inc    = 2'd0;
    start_sof   = 1'b0;
    start_ptr   = wr_ptr;
    if (mac_rx_valid) begin
      unique case (rx_state)
        R_IDLE: start_sof = mac_rx_sof;
        R_RECV: begin
          if (mac_rx_sof) begin
            drop_inc  = 2'd1;
            start_ptr = wr_base;
            start_sof = 1'b1;
          end else if (ptr_full(wr_ptr, rd_ptr)) begin
            drop_inc   = 2'd1;
            wr_ptr_nxt = wr_base;
            rx_nxt     = mac_rx_eof ? R_IDLE : R_DROP;
          end else if (mac_rx_eof) begin
            rx_nxt = R_IDLE;
            if (frame_ok) begin
              mem_we     = 1'b1;
              wr_ptr_nxt = wr_ptr + ONE;
              lf_push    = 1'b1;
              push_len   = wr_ptr - wr_base + ONE;
            end else begin
              drop_inc   = 2'd1;
              wr_ptr_nxt = wr_base;
            end
          end else begin
            mem_we     = 1'b1;
            wr_ptr_nxt = wr_ptr + ONE;
          end
        end
        R_DROP: begin
          if (mac_rx_sof)      start_sof = 1'b1;
          else if (mac_rx_eof) rx_nxt    = R_IDLE;
        end
        default: rx_nxt = R_IDLE;
      endcase
      if (start_sof) begin
        wr_ptr_nxt = start_ptr;
        rx_nxt     = mac_rx_eof ? R_IDLE : R_DROP;
        if (!enable || lf_full || ptr_full(start_ptr, rd_ptr) || (mac_rx_eof && !frame_ok)) begin
          drop_inc = drop_inc + 2'd1;
        end else begin
          mem_we      = 1'b1;
          mem_wa      = start_ptr[ADDR_WIDTH-1:0];
          wr_base_nxt = start_ptr;
          wr_ptr_nxt  = start_ptr + ONE;
          if (mac_rx_eof) begin
            lf_push  = 1'b1;
            push_len = ONE;
          end else begin
            rx_nxt = R_RECV;
          end
        end
      end
    end
  end

  // Transmit side: p0 issues buffer reads, p1 holds read data, output registers follow.
  always_comb begin
    tx_nxt      = tx_state;
    lf_pop      = 1'b0;
    rd_en_p0    = 1'b0;
    sof_p0      = 1'b0;
    eof_p0      = 1'b0;
    len_rem_nxt = len_rem;
    ifg_nxt     = ifg_cnt;
    unique case (tx_state)
      T_IDLE: begin
        if (!lf_empty) begin
          lf_pop   = 1'b1;
          rd_en_p0 = 1'b1;
          sof_p0   = 1'b1;
          if (head_len == ONE) begin
            eof_p0 = 1'b1;
          end else begin
            len_rem_nxt = head_len - ONE;
            tx_nxt      = T_SEND;
          end
        end
      end
      T_SEND: begin
        rd_en_p0    = 1'b1;
        len_rem_nxt = len_rem - ONE;
        eof_p0      = (len_rem == ONE);
      end
      T_GAP: begin
        if (ifg_cnt == 16'd0) tx_nxt  = T_IDLE;
        else                  ifg_nxt = ifg_cnt - 16'd1;
      end
      default: tx_nxt = T_IDLE;
    endcase
    if (eof_p0) begin
      tx_nxt  = (IFG_CYCLES == 0) ? T_IDLE : T_GAP;
      ifg_nxt = IFG_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)  buf_mem[mem_wa] <= mac_rx_data;
    if (lf_push) len_mem[lf_wr[LEN_FIFO_AW-1:0]] <= push_len;
    data_p1 <= buf_mem[rd_ptr[ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state     <= R_IDLE;
      tx_state     <= T_IDLE;
      wr_ptr       <= '0;
      wr_base      <= '0;
      rd_ptr       <= '0;
      lf_wr        <= '0;
      lf_rd        <= '0;
      len_rem      <= '0;
      ifg_cnt      <= '0;
      vld_p1       <= 1'b0;
      sof_p1       <= 1'b0;
      eof_p1       <= 1'b0;
      mac_tx_valid <= 1'b0;
      mac_tx_sof   <= 1'b0;
      mac_tx_eof   <= 1'b0;
      mac_tx_data  <= '0;
      frame_cnt    <= '0;
      drop_cnt     <= '0;
    end else begin
      rx_state <= rx_nxt;
      tx_state <= tx_nxt;
      wr_ptr   <= wr_ptr_nxt;
      wr_base  <= wr_base_nxt;
      if (rd_en_p0) rd_ptr <= rd_ptr + ONE;
      if (lf_push)  lf_wr  <= lf_wr + 1'b1;
      if (lf_pop)   lf_rd  <= lf_rd + 1'b1;
      len_rem  <= len_rem_nxt;
      ifg_cnt  <= ifg_nxt;
      drop_cnt <= drop_cnt + 16'(drop_inc);
      // p1: read data returns one cycle after issue
      vld_p1 <= rd_en_p0;
      sof_p1 <= sof_p0;
      eof_p1 <= eof_p0;
      // p2: registered MAC tx outputs
      mac_tx_valid <= vld_p1;
      mac_tx_sof   <= vld_p1 & sof_p1;
      mac_tx_eof   <= vld_p1 & eof_p1;
      mac_tx_data  <= vld_p1 ? data_p1 : '0;
      if (vld_p1 && eof_p1) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_test_loopback.sv
// Scoreboard bench for test_loopback: echoed beats are queued at rx time and
// popped as the DUT transmits; counters, latency and inter-frame gap are checked.
module tb_test_loopback;
  localparam int DW  = 8;
  localparam int AW  = 11;
  localparam int IFG = 200;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [DW-1:0] mac_rx_data = '0;
  logic mac_rx_valid = 1'b0, mac_rx_sof = 1'b0, mac_rx_eof = 1'b0;
  logic mac_rx_fr_good = 1'b0, mac_rx_fr_err = 1'b0;
  logic enable = 1'b1;
  logic [DW-1:0] mac_tx_data;
  logic mac_tx_valid, mac_tx_sof, mac_tx_eof, busy;
  logic [15:0] frame_cnt, drop_cnt;

  logic [31:0] sb [$];
  int n_vec = 0, n_fail = 0;
  int cyc = 0, n_beats = 0, n_sof = 0;
  int last_eof_cyc = 0, last_sof_cyc = 0, prev_tx_eof = 0;
  int gap_from = 0;
  bit gap_check = 1'b0;
  int exp_frames = 0, exp_drops = 0;

  test_loopback #(
    .TEST_DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_FIFO_AW(2), .IFG_CYCLES(IFG)
  ) dut (
    .clk(clk), .rst(rst),
    .mac_rx_data(mac_rx_data), .mac_rx_valid(mac_rx_valid),
    .mac_rx_sof(mac_rx_sof), .mac_rx_eof(mac_rx_eof),
    .mac_rx_fr_good(mac_rx_fr_good), .mac_rx_fr_err(mac_rx_fr_err),
    .mac_tx_data(mac_tx_data), .mac_tx_valid(mac_tx_valid),
    .mac_tx_sof(mac_tx_sof), .mac_tx_eof(mac_tx_eof),
    .enable(enable), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst && mac_tx_valid) begin
      logic [31:0] got;
      got = {22'b0, mac_tx_eof, mac_tx_sof, mac_tx_data};
      n_beats++;
      if (sb.size() == 0) chk("extra_beat", got, 32'hFFFF_FFFF);
      else                chk("beat", got, sb.pop_front());
      if (mac_tx_sof) begin
        n_sof++;
        if (gap_check && n_sof > gap_from) chk("ifg", 32'(cyc - prev_tx_eof - 1), IFG);
        last_sof_cyc = cyc;
      end
      if (mac_tx_eof) prev_tx_eof = cyc;
    end
  end

  task automatic send_frame(input int len, input int seed, input bit good, input bit err,
                            input bit echo, input bit term);
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      mac_rx_valid   = 1'b1;
      mac_rx_data    = DW'(seed + i);
      mac_rx_sof     = (i == 0);
      mac_rx_eof     = term && (i == len - 1);
      mac_rx_fr_good = good;
      mac_rx_fr_err  = err;
      if (echo) sb.push_back({22'b0, mac_rx_eof, mac_rx_sof, mac_rx_data});
      if (mac_rx_eof) last_eof_cyc = cyc + 1;
    end
    @(posedge clk); #1;
    mac_rx_valid = 1'b0;
    mac_rx_sof   = 1'b0;
    mac_rx_eof   = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 6000 && !done; i++) begin
      @(negedge clk);
      done = !busy && !mac_tx_valid && (sb.size() == 0);
    end
    if (!done) chk({tag, "_idle_timeout"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_frame_cnt"}, {16'b0, frame_cnt}, 32'(exp_frames));
    chk({tag, "_drop_cnt"}, {16'b0, drop_cnt}, 32'(exp_drops));
    chk({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, mac_tx_valid}, 0);
    chk("rst_sof", {31'b0, mac_tx_sof}, 0);
    chk("rst_eof", {31'b0, mac_tx_eof}, 0);
    chk("rst_data", {24'b0, mac_tx_data}, 0);
    chk("rst_frame_cnt", {16'b0, frame_cnt}, 0);
    chk("rst_drop_cnt", {16'b0, drop_cnt}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    rst = 1'b1;

    // 64-byte good frame, fixed 3-cycle turnaround
    send_frame(64, 0, 1, 0, 1, 1); exp_frames++;
    wait_idle("t1");
    chk("t1_sof_latency", 32'(last_sof_cyc - last_eof_cyc), 32'd2);
    check_counts("t1");

    // errored frame then good frame
    send_frame(20, 'h80, 1, 1, 0, 1); exp_drops++;
    send_frame(10, 'h40, 1, 0, 1, 1); exp_frames++;
    wait_idle("t2");
    check_counts("t2");

    // tx held in its gap by a lead frame; four frames fill the length FIFO, the fifth drops
    gap_from  = n_sof + 1;
    gap_check = 1'b1;
    send_frame(16, 'h10, 1, 0, 1, 1); exp_frames++;
    for (int k = 0; k < 5; k++) send_frame(16, 'h20 + 16 * k, 1, 0, (k < 4), 1);
    exp_frames += 4; exp_drops++;
    wait_idle("t3");
    gap_check = 1'b0;
    check_counts("t3");

    // overflow of the 2048-beat buffer, then a normal frame
    send_frame(3000, 0, 1, 0, 0, 1); exp_drops++;
    send_frame(8, 'hA0, 1, 0, 1, 1); exp_frames++;
    wait_idle("t4");
    check_counts("t4");

    // unterminated frame restarted by a new sof, then a single-beat frame
    send_frame(5, 'h50, 1, 0, 0, 0);
    send_frame(12, 'h60, 1, 0, 1, 1); exp_drops++; exp_frames++;
    send_frame(1, 'h77, 1, 0, 1, 1); exp_frames++;
    wait_idle("t5");
    check_counts("t5");

    // disabled input drops the frame
    enable = 1'b0;
    send_frame(6, 'h30, 1, 0, 0, 1); exp_drops++;
    enable = 1'b1;
    wait_idle("t6");
    check_counts("t6");

    // reset in the middle of a 100-beat transmission
    send_frame(100, 'h05, 1, 0, 1, 1);
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      seen = (sb.size() <= 70);
    end
    chk("t7_midframe_reached", {31'b0, seen}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    sb.delete();
    exp_frames = 0; exp_drops = 0;
    chk("t7_rst_valid", {31'b0, mac_tx_valid}, 0);
    chk("t7_rst_frame_cnt", {16'b0, frame_cnt}, 0);
    chk("t7_rst_drop_cnt", {16'b0, drop_cnt}, 0);
    chk("t7_rst_busy", {31'b0, busy}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    send_frame(8, 'hC3, 1, 0, 1, 1); exp_frames++;
    wait_idle("t7");
    check_counts("t7");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/test_loopback.md
Name: test_loopback

Overview:
- Far-end echo block for the PHY/MAC link test path.
- Accepts frames from the MAC receive interface into a ring buffer, commits only frames reported good, and retransmits them unchanged on the MAC transmit interface.
- The test generator/checker pair at the other end of the link sees its own traffic returned.
- Store-and-forward; bad, aborted or overflowing frames are discarded and counted.

Parameters:
- TEST_DATA_WIDTH, 8, width of MAC data beats.
- ADDR_WIDTH, 11, log2 of data buffer depth in beats (default 2048).
- LEN_FIFO_AW, 2, log2 of committed-frame length FIFO depth (default 4 frames).
- IFG_CYCLES, 12, minimum idle cycles between the eof of one tx frame and the sof of the next.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous reset, active-low.
- mac_rx_data  in  TEST_DATA_WIDTH  receive beat.
- mac_rx_valid  in  1  beat qualifier; gaps allowed inside a frame.
- mac_rx_sof  in  1  first beat; meaningful only with valid.
- mac_rx_eof  in  1  last beat; meaningful only with valid.
- mac_rx_fr_good  in  1  frame status; sampled on the eof beat.
- mac_rx_fr_err  in  1  frame status; sampled on the eof beat.
- mac_tx_data  out  TEST_DATA_WIDTH  transmit beat.
- mac_tx_valid  out  1  beat qualifier; no backpressure, so every valid beat is consumed.
- mac_tx_sof  out  1  first beat of a tx frame.
- mac_tx_eof  out  1  last beat of a tx frame.
- enable  in  1  0: all new rx frames are dropped; a tx frame in flight completes.
- frame_cnt  out  16  frames retransmitted (counted at tx eof); wraps.
- drop_cnt  out  16  frames discarded; wraps.
- busy  out  1  a committed frame is pending or being transmitted.

Behaviour:
- Reset (rst=0, async): all pointers cleared, length FIFO empty, tx FSM in IDLE, IFG counter loaded to 0. All outputs are 0: mac_tx_* = 0, counters = 0, busy = 0.
- Buffer pointers: ADDR_WIDTH+1 bits each.
  - wr_ptr: speculative write pointer.
  - wr_base: start of the frame being received.
  - rd_ptr: tx read pointer.
  - Free space = 2^ADDR_WIDTH - (wr_ptr - rd_ptr), modulo arithmetic.
- RX FSM, states R_IDLE, R_RECV, R_DROP:
  - R_IDLE + valid&sof:
    - If enable=1 and the length FIFO is not full: write the beat, set wr_base = wr_ptr before the write, go to R_RECV.
    - Otherwise: drop_cnt++ and go to R_DROP. A frame that is both sof and eof in this case is counted once and the FSM stays in R_IDLE.
  - R_RECV, each valid beat is written and wr_ptr++. If the buffer is full on a valid beat: rewind wr_ptr = wr_base, drop_cnt++, go to R_DROP.
  - R_RECV + valid&eof:
    - fr_good=1 and fr_err=0: push length (wr_ptr - wr_base + 1) into the length FIFO, go to R_IDLE.
    - Any other status: rewind, drop_cnt++, go to R_IDLE.
  - R_RECV + valid&sof (new sof without a prior eof): rewind, drop_cnt++, then treat the beat as the sof of a new frame with the R_IDLE rules in the same cycle.
  - R_DROP: ignore beats until valid&eof, then go to R_IDLE. A valid&sof in R_DROP restarts with the R_IDLE rules.
  - Single-beat frame (sof&eof together): length 1, handled fully in one cycle.
  - Valid beats in R_IDLE without sof are ignored.
- TX FSM, states T_IDLE, T_SEND, T_GAP:
  - T_IDLE: when the length FIFO is not empty, pop the length and issue the first buffer read, go to T_SEND.
  - Buffer read latency is 1 cycle; tx outputs are registered.
  - An rx eof committed in cycle N, with tx in T_IDLE, gives the first mac_tx_valid/sof at cycle N+3.
  - T_SEND: one beat per cycle with no gaps. rd_ptr++ per beat. sof on beat 0, eof on the last beat, both together for length 1.
  - After eof: frame_cnt++, load the IFG counter, go to T_GAP.
  - T_GAP: mac_tx_valid=0 for exactly IFG_CYCLES cycles, then T_IDLE. IFG_CYCLES=0 allows back-to-back frames.
- rd_ptr advances as beats are read, so buffer space frees during transmission.
- Simultaneous events:
  - Length FIFO push and pop in the same cycle are both honoured.
  - A buffer write and read in the same cycle use a true dual-port memory or separate write/read ports.
- busy = length FIFO not empty, or tx state is not T_IDLE.
- enable deasserted in R_RECV: the current frame still completes normally; enable is checked only at sof.

Test Plan:
- Single 64-byte frame 0x00..0x3F with fr_good -> identical 64 beats out, sof on 0x00, eof on 0x3F, first sof 3 cycles after rx eof, frame_cnt=1, drop_cnt=0.
- Frame of 20 beats with fr_err=1 at eof, then a 10-beat good frame -> only the 10-beat frame is transmitted, drop_cnt=1, buffer contents contiguous.
- Five back-to-back 16-beat good frames while tx is stalled by IFG_CYCLES=200 -> the fifth frame is dropped (length FIFO full), drop_cnt=1, and frames 1-4 are output with exactly 200 idle cycles between eof and the next sof.
- 3000-beat good frame with ADDR_WIDTH=11 -> dropped at beat 2049, drop_cnt=1, nothing transmitted, the next 8-beat frame is echoed correctly.
- sof at beat 5 of an unterminated frame, then the new frame ends at 12 beats -> first frame dropped, second echoed with 12 beats; a 1-beat sof&eof frame gives sof&eof&valid on one tx cycle.
- rst pulsed low mid-transmission of a 100-beat frame -> mac_tx_valid drops to 0 immediately, counters=0, busy=0, and the next received frame is echoed correctly.
